// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared state type and constants for operand_loader.
// OPERAND_LOADER_PARITY_EN adds the LOAD_P state.
package operand_loader_pkg;
    localparam int OPW = 4;
    localparam int TIMEOUT_CYC_DEF = 15;
`ifdef OPERAND_LOADER_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, HOLD, LOAD_P} state_e;
`else
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_e;
`endif
endpackage

// File: rtl/loader_shift4.sv
// loader_shift4: MSB-first shadow shift register with clear and load-enable.
// nxt exposes the value being written this cycle so the loader can commit without a bubble.
module loader_shift4
    import operand_loader_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           en,
    input  logic           din,
    output logic [OPW-1:0] nxt
);
    logic [OPW-1:0] sh_q, sh_d;

    always_comb sh_d = clr ? '0 : en ? {sh_q[OPW-2:0], din} : sh_q;

    assign nxt = sh_d;

    always_ff @(posedge clk) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= sh_d;
    end
endmodule

// File: rtl/operand_loader.sv
// operand_loader: serially loads 4-bit operands A and B and commits them atomically for a comparator.
// Define OPERAND_LOADER_PARITY_EN to require a trailing even-parity bit before commit.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ser_in,
    input  logic ser_valid,
    input  logic ack,
    output logic a3, a2, a1, a0,
    output logic b3, b2, b1, b0,
    output logic ops_valid,
    output logic busy,
    output logic err
);
    localparam logic [7:0] TO = 8'(TIMEOUT_CYC);

    state_e         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [7:0]     idle_q, idle_d, idle_inc;
    logic           err_q, err_d;
    logic [OPW-1:0] a_q, a_d, b_q, b_d, sh_a, sh_b;
    logic           clr, en_a, en_b;

    assign clr  = (state_q == IDLE) && start;
    assign en_a = (state_q == LOAD_A) && ser_valid;
    assign en_b = (state_q == LOAD_B) && ser_valid;

    loader_shift4 u_sh_a (.clk(clk), .rst_n(rst_n), .clr(clr), .en(en_a), .din(ser_in), .nxt(sh_a));
    loader_shift4 u_sh_b (.clk(clk), .rst_n(rst_n), .clr(clr), .en(en_b), .din(ser_in), .nxt(sh_b));

`ifdef OPERAND_LOADER_PARITY_EN
    assign busy = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_P);
`else
    assign busy = (state_q == LOAD_A) || (state_q == LOAD_B);
`endif
    assign ops_valid = (state_q == HOLD);
    assign err       = err_q;
    assign {a3, a2, a1, a0} = a_q;
    assign {b3, b2, b1, b0} = b_q;

    // Saturating so a long stall can never wrap back below the threshold
    assign idle_inc = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        err_d   = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        if (busy && ser_valid) begin
            cnt_d  = cnt_q + 2'd1;
            idle_d = '0;
        end else if (busy) begin
            idle_d = idle_inc;
            if (idle_inc >= TO) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD_A;
                cnt_d   = '0;
                idle_d  = '0;
            end
            LOAD_A: if (ser_valid && cnt_q == 2'd3) state_d = LOAD_B;
            LOAD_B: if (ser_valid && cnt_q == 2'd3) begin
`ifdef OPERAND_LOADER_PARITY_EN
                state_d = LOAD_P;
`else
                state_d = HOLD;
                a_d     = sh_a;
                b_d     = sh_b;
`endif
            end
`ifdef OPERAND_LOADER_PARITY_EN
            LOAD_P: if (ser_valid) begin
                if (ser_in == ^{sh_a, sh_b}) begin
                    state_d = HOLD;
                    a_d     = sh_a;
                    b_d     = sh_b;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
`endif
            HOLD: if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed self-checking bench for operand_loader.
module tb_operand_loader;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ser_in = 1'b0, ser_valid = 1'b0, ack = 1'b0;
    logic a3, a2, a1, a0, b3, b2, b1, b0, ops_valid, busy, err;
    logic [3:0] a_o, b_o;
    int checks = 0, failures = 0, err_seen = 0;

    assign a_o = {a3, a2, a1, a0};
    assign b_o = {b3, b2, b1, b0};

    always #5 clk = ~clk;

    operand_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ser_in(ser_in), .ser_valid(ser_valid), .ack(ack),
        .a3(a3), .a2(a2), .a1(a1), .a0(a0), .b3(b3), .b2(b2), .b1(b1), .b0(b0),
        .ops_valid(ops_valid), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (err) err_seen++;
    endtask

    task automatic send(input logic b);
        ser_valid = 1'b1;
        ser_in    = b;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] pa, input logic [3:0] pb, input int gap);
        logic [7:0] v;
        v = {a, b};
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                check("partial_a", a_o, pa);
                check("partial_b", b_o, pb);
                check("load_busy", busy, 1);
            end
            send(v[i]);
            if (i > 0) repeat (gap) tick();
        end
`ifdef OPERAND_LOADER_PARITY_EN
        repeat (gap) tick();
        send(^v);
`endif
    endtask

    initial begin
        repeat (2) tick();
        check("rst_a", a_o, 0);
        check("rst_b", b_o, 0);
        check("rst_valid", ops_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        kick();
        check("start_busy", busy, 1);
        check("start_valid", ops_valid, 0);
        load(4'hB, 4'h6, 4'h0, 4'h0, 0);
        check("nom_a", a_o, 4'hB);
        check("nom_b", b_o, 4'h6);
        check("nom_valid", ops_valid, 1);
        check("nom_busy", busy, 0);
        check("nom_err", err, 0);

        send(1'b0);
        send(1'b1);
        check("hold_ign_a", a_o, 4'hB);
        check("hold_ign_b", b_o, 4'h6);
        check("hold_ign_valid", ops_valid, 1);

        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        check("ack_valid", ops_valid, 0);
        check("ack_busy", busy, 0);
        check("ack_keep_a", a_o, 4'hB);
        tick();
        check("ack_start_ign", busy, 0);

        send(1'b1);
        check("idle_ser_ign", busy, 0);

        err_seen = 0;
        kick();
        load(4'hB, 4'h6, 4'hB, 4'h6, 3);
        check("gap_a", a_o, 4'hB);
        check("gap_b", b_o, 4'h6);
        check("gap_valid", ops_valid, 1);
        check("gap_no_err", err_seen, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        kick();
        send(1'b1);
        send(1'b1);
        repeat (14) tick();
        check("to_pre_busy", busy, 1);
        check("to_pre_err", err, 0);
        tick();
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_valid", ops_valid, 0);
        check("to_a", a_o, 4'hB);
        check("to_b", b_o, 4'h6);
        tick();
        check("to_err_pulse", err, 0);

        kick();
        send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_a", a_o, 0);
        check("mrst_b", b_o, 0);
        check("mrst_busy", busy, 0);
        check("mrst_valid", ops_valid, 0);
        check("mrst_err", err, 0);
        tick();
        check("mrst_no_err", err, 0);
        kick();
        load(4'h5, 4'hC, 4'h0, 4'h0, 0);
        check("reload_a", a_o, 4'h5);
        check("reload_b", b_o, 4'hC);
        check("reload_valid", ops_valid, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

`ifdef OPERAND_LOADER_PARITY_EN
        kick();
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        send(1'b0);
        check("par_bad_err", err, 1);
        check("par_bad_valid", ops_valid, 0);
        check("par_bad_a", a_o, 4'h5);
        check("par_bad_b", b_o, 4'hC);
        kick();
        load(4'hB, 4'h6, 4'h5, 4'hC, 0);
        check("par_ok_a", a_o, 4'hB);
        check("par_ok_b", b_o, 4'h6);
        check("par_ok_valid", ops_valid, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
